// File: rtl/switch_input_fifo_if.sv
// Handshake/data bundle between the switch-capture FIFO and its producer/consumer side.
// The master side drives confirm/sw/rd_en/ovf_clr; the slave (FIFO) drives the status and head data.
interface switch_input_fifo_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 3
);
  logic              confirm;
  logic [DATA_W-1:0] sw;
  logic              rd_en;
  logic              ovf_clr;
  logic [DATA_W-1:0] rd_data;
  logic              valid;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  modport master (
    output confirm, sw, rd_en, ovf_clr,
    input  rd_data, valid, full, count, overflow
  );

  modport slave (
    input  confirm, sw, rd_en, ovf_clr,
    output rd_data, valid, full, count, overflow
  );
endinterface

// File: rtl/switch_input_fifo.sv
// Captures synchronised switch values on each confirm-key rising edge into a small
// first-word-fall-through FIFO that the CPU drains through its MMIO load path.
module switch_input_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rstn,
  switch_input_fifo_if.slave  fifo_if
);
  localparam int PTR_W = $clog2(DEPTH);

  logic              c1_q, c2_q, c3_q;
  logic [DATA_W-1:0] s1_q, s2_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic push, valid, full, do_pop, do_push;

  always_comb begin
    push     = c2_q & ~c3_q;
    valid    = (count_q != '0);
    full     = (count_q == CNT_W'(DEPTH));
    do_pop   = fifo_if.rd_en & valid;
    // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands.
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    ovf_d    = ovf_q;
    if (push & ~do_push)
      ovf_d = 1'b1;
    else if (fifo_if.ovf_clr)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c1_q     <= 1'b0;
      c2_q     <= 1'b0;
      c3_q     <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      c1_q     <= fifo_if.confirm;
      c2_q     <= c1_q;
      c3_q     <= c2_q;
      s1_q     <= fifo_if.sw;
      s2_q     <= s1_q;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage carries no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wr_ptr_q] <= s2_q;
  end

  assign fifo_if.rd_data  = valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_if.valid    = valid;
  assign fifo_if.full     = full;
  assign fifo_if.count    = count_q;
  assign fifo_if.overflow = ovf_q;
endmodule

// File: tb/tb_switch_input_fifo.sv
// Bench for switch_input_fifo: directed test-plan scenarios followed by random traffic,
// all checked against a queue-based reference model of the capture FIFO.
module tb_switch_input_fifo;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  switch_input_fifo_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) fifo_if ();

  switch_input_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .fifo_if (fifo_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted entries. A confirm rising edge seen at
  // edge N becomes a push attempt at edge N+2 carrying the switch value seen at N.
  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } pend_t;

  pend_t             pend[$];
  logic [DATA_W-1:0] exp_q[$];
  bit                m_ovf = 1'b0;
  bit                conf_prev = 1'b0;
  int                cyc = 0;

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      pend.delete();
      exp_q.delete();
      m_ovf     = 1'b0;
      conf_prev = 1'b0;
    end else begin
      bit                pop, push, drop;
      logic [DATA_W-1:0] pdata;
      cyc++;
      pop   = fifo_if.rd_en && (exp_q.size() > 0);
      push  = 1'b0;
      pdata = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        push  = 1'b1;
        pdata = pend[0].data;
        void'(pend.pop_front());
      end
      drop = push && (exp_q.size() == DEPTH) && !pop;
      if (pop) void'(exp_q.pop_front());
      if (push && !drop) exp_q.push_back(pdata);
      if (drop) m_ovf = 1'b1;
      else if (fifo_if.ovf_clr) m_ovf = 1'b0;
      if (fifo_if.confirm && !conf_prev) pend.push_back('{cyc + 2, fifo_if.sw});
      conf_prev = fifo_if.confirm;
    end
  end

  // Monitor: compares the DUT's presented state with the model every falling edge.
  initial forever begin
    @(negedge clk);
    if (mon_en && rstn) begin
      chk("mon_count", 32'(fifo_if.count), 32'(exp_q.size()));
      chk("mon_valid", 32'(fifo_if.valid), 32'(exp_q.size() != 0));
      chk("mon_full", 32'(fifo_if.full), 32'(exp_q.size() == DEPTH));
      chk("mon_overflow", 32'(fifo_if.overflow), 32'(m_ovf));
      chk("mon_rd_data", 32'(fifo_if.rd_data),
          (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_confirm(input logic [DATA_W-1:0] d);
    fifo_if.sw      = d;
    fifo_if.confirm = 1'b1;
    step();
    step();
    fifo_if.confirm = 1'b0;
    step();
    step();
  endtask

  task automatic pop_one();
    fifo_if.rd_en = 1'b1;
    step();
    fifo_if.rd_en = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_count"}, 32'(fifo_if.count), 32'd0);
    chk({tag, "_valid"}, 32'(fifo_if.valid), 32'd0);
    chk({tag, "_full"}, 32'(fifo_if.full), 32'd0);
    chk({tag, "_overflow"}, 32'(fifo_if.overflow), 32'd0);
    chk({tag, "_rd_data"}, 32'(fifo_if.rd_data), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fifo_if.confirm = 1'b0;
    fifo_if.sw      = '0;
    fifo_if.rd_en   = 1'b0;
    fifo_if.ovf_clr = 1'b0;
    #2 rstn = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    rstn = 1'b1;
    mon_en = 1'b1;
    step();

    // Single capture: visible exactly two edges after confirm is first sampled.
    fifo_if.sw      = 16'hA5A5;
    fifo_if.confirm = 1'b1;
    step();
    fifo_if.confirm = 1'b0;
    chk("lat_n", 32'(fifo_if.valid), 32'd0);
    step();
    chk("lat_n1", 32'(fifo_if.valid), 32'd0);
    step();
    chk("lat_valid", 32'(fifo_if.valid), 32'd1);
    chk("lat_count", 32'(fifo_if.count), 32'd1);
    chk("lat_data", 32'(fifo_if.rd_data), 32'hA5A5);
    pop_one();
    chk("pop_valid", 32'(fifo_if.valid), 32'd0);
    chk("pop_data", 32'(fifo_if.rd_data), 32'd0);

    // Held confirm gives a single push.
    fifo_if.sw      = 16'h0001;
    fifo_if.confirm = 1'b1;
    repeat (20) step();
    fifo_if.confirm = 1'b0;
    step();
    step();
    step();
    chk("hold_count", 32'(fifo_if.count), 32'd1);
    pop_one();

    // Overfill then drain in order.
    for (int i = 1; i <= 5; i++) do_confirm(DATA_W'(i));
    chk("ovf_full", 32'(fifo_if.full), 32'd1);
    chk("ovf_count", 32'(fifo_if.count), 32'd4);
    chk("ovf_flag", 32'(fifo_if.overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", 32'(fifo_if.rd_data), 32'(i));
      pop_one();
    end
    chk("drain_valid", 32'(fifo_if.valid), 32'd0);
    fifo_if.ovf_clr = 1'b1;
    step();
    fifo_if.ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(fifo_if.overflow), 32'd0);

    // Full FIFO: push coincident with pop, then drop racing ovf_clr.
    for (int i = 10; i <= 13; i++) do_confirm(DATA_W'(i));
    fifo_if.sw      = 16'd14;
    fifo_if.confirm = 1'b1;
    step();
    step();
    fifo_if.rd_en = 1'b1;
    step();
    fifo_if.rd_en   = 1'b0;
    fifo_if.confirm = 1'b0;
    chk("pp_count", 32'(fifo_if.count), 32'd4);
    chk("pp_ovf", 32'(fifo_if.overflow), 32'd0);
    chk("pp_head", 32'(fifo_if.rd_data), 32'd11);
    step();
    fifo_if.sw      = 16'd99;
    fifo_if.confirm = 1'b1;
    step();
    step();
    fifo_if.ovf_clr = 1'b1;
    step();
    fifo_if.ovf_clr = 1'b0;
    fifo_if.confirm = 1'b0;
    chk("race_ovf", 32'(fifo_if.overflow), 32'd1);
    chk("race_count", 32'(fifo_if.count), 32'd4);
    fifo_if.ovf_clr = 1'b1;
    step();
    fifo_if.ovf_clr = 1'b0;
    chk("clr_ovf", 32'(fifo_if.overflow), 32'd0);
    for (int i = 11; i <= 14; i++) begin
      chk("order_data", 32'(fifo_if.rd_data), 32'(i));
      pop_one();
    end

    // Reads while empty are ignored.
    fifo_if.rd_en = 1'b1;
    step();
    step();
    step();
    fifo_if.rd_en = 1'b0;
    chk("underflow_count", 32'(fifo_if.count), 32'd0);
    do_confirm(16'h00FF);
    chk("after_uf_count", 32'(fifo_if.count), 32'd1);
    chk("after_uf_data", 32'(fifo_if.rd_data), 32'h00FF);
    pop_one();
    fifo_if.sw      = 16'd7;
    fifo_if.confirm = 1'b1;
    step();
    step();
    fifo_if.rd_en = 1'b1;
    step();
    fifo_if.rd_en   = 1'b0;
    fifo_if.confirm = 1'b0;
    chk("empty_pp_count", 32'(fifo_if.count), 32'd1);
    chk("empty_pp_data", 32'(fifo_if.rd_data), 32'd7);
    pop_one();
    step();

    // Pointer wrap-around.
    for (int i = 0; i < 10; i++) begin
      do_confirm(DATA_W'(i));
      chk("wrap_data", 32'(fifo_if.rd_data), 32'(i));
      pop_one();
    end

    // Reset mid-sequence.
    do_confirm(16'h1111);
    do_confirm(16'h2222);
    fifo_if.sw      = 16'h3333;
    fifo_if.confirm = 1'b1;
    step();
    rstn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    step();
    fifo_if.confirm = 1'b0;
    rstn = 1'b1;
    step();
    step();
    step();
    chk("post_rst_valid", 32'(fifo_if.valid), 32'd0);
    chk("post_rst_count", 32'(fifo_if.count), 32'd0);

    // Random traffic, including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 30) fifo_if.confirm = ~fifo_if.confirm;
      fifo_if.sw      = DATA_W'($urandom);
      fifo_if.rd_en   = ($urandom_range(0, 99) < 25);
      fifo_if.ovf_clr = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 999) < 3) begin
        rstn = 1'b0;
        #1;
        chk_all_zero("rand_rst");
        step();
        rstn = 1'b1;
      end
      step();
    end
    fifo_if.rd_en   = 1'b0;
    fifo_if.ovf_clr = 1'b0;
    fifo_if.confirm = 1'b0;
    step();
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
